// File: rtl/argmax_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_scheduler_pkg
//  Description : Shared defaults and state encoding for the folded argmax
//                scheduler and its compare helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package argmax_scheduler_pkg;

    localparam int DEF_DATA_WIDTH  = 42;
    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_IDX_WIDTH   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/argmax_scheduler_score_max_update.sv
`default_nettype none
// ============================================================================
//  Module      : score_max_update
//  Description : Combinational running-maximum step: signed strict-greater
//                compare, so ties keep the earlier (lower) index.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_max_update
    import argmax_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IDX_WIDTH  = DEF_IDX_WIDTH
)(
    input  logic                  first,
    input  logic [DATA_WIDTH-1:0] new_score,
    input  logic [IDX_WIDTH-1:0]  new_idx,
    input  logic [DATA_WIDTH-1:0] best_score,
    input  logic [IDX_WIDTH-1:0]  best_idx,
    output logic [DATA_WIDTH-1:0] next_score,
    output logic [IDX_WIDTH-1:0]  next_idx
);

    logic w_take;

    // The first class loads unconditionally so an all-negative run is correct.
    always_comb begin
        w_take     = first || ($signed(new_score) > $signed(best_score));
        next_score = w_take ? new_score : best_score;
        next_idx   = w_take ? new_idx   : best_idx;
    end

endmodule
`default_nettype wire

// File: rtl/argmax_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_scheduler
//  Description : Walks the folded output layer one class at a time, tracks the
//                signed maximum and hands the winning index downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module argmax_scheduler
    import argmax_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int IDX_WIDTH   = DEF_IDX_WIDTH
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  score_req,
    output logic [IDX_WIDTH-1:0]  score_idx,
    input  logic                  score_valid,
    input  logic [DATA_WIDTH-1:0] score_data,
    output logic                  score_ready,
    output logic                  pred_valid,
    input  logic                  pred_ready,
    output logic [7:0]            predict,
    output logic [DATA_WIDTH-1:0] max_score,
    output logic                  proto_err
);

    localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [IDX_WIDTH-1:0]  r_k;
    logic [IDX_WIDTH-1:0]  r_best_idx;
    logic [IDX_WIDTH-1:0]  w_next_idx;
    logic [DATA_WIDTH-1:0] r_best_score;
    logic [DATA_WIDTH-1:0] w_next_score;
    logic                  r_proto_err;
    logic                  w_accept;
    logic                  w_first;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        score_req    = 1'b0;
        score_ready  = 1'b0;
        pred_valid   = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                score_req    = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                score_ready = 1'b1;
                if (score_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = (r_k == c_LAST_IDX) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                pred_valid = 1'b1;
                if (pred_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_first = (r_k == '0);

    score_max_update #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_update (
        .first      (w_first),
        .new_score  (score_data),
        .new_idx    (r_k),
        .best_score (r_best_score),
        .best_idx   (r_best_idx),
        .next_score (w_next_score),
        .next_idx   (w_next_idx)
    );

    // Best registers double as the output holding registers: they stay put
    // through DONE and IDLE until class 0 of the next run is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k          <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_k         <= '0;
                r_proto_err <= 1'b0;
            end
            if (score_valid && r_state != S_WAIT) begin
                r_proto_err <= 1'b1;
            end
            if (w_accept) begin
                r_best_score <= w_next_score;
                r_best_idx   <= w_next_idx;
                if (r_k != c_LAST_IDX) begin
                    r_k <= r_k + 1'b1;
                end
            end
        end
    end

    always_comb begin
        predict                 = '0;
        predict[IDX_WIDTH-1:0]  = r_best_idx;
    end

    assign score_idx = r_k;
    assign max_score = r_best_score;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_argmax_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_argmax_scheduler
//  Description : Self-checking bench for argmax_scheduler (vector table plus
//                reset/protocol corner sequences, scoreboarded predictions).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_argmax_scheduler;

    localparam int DW = 42;
    localparam int NC = 10;
    localparam int IW = 4;
    localparam logic [DW-1:0] MAXP = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MINN = {1'b1, {(DW-1){1'b0}}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          score_valid = 1'b0;
    logic          pred_ready = 1'b0;
    logic [DW-1:0] score_data = '0;
    logic          busy, score_req, score_ready, pred_valid, proto_err;
    logic [IW-1:0] score_idx;
    logic [7:0]    predict;
    logic [DW-1:0] max_score;

    argmax_scheduler #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .score_req   (score_req),
        .score_idx   (score_idx),
        .score_valid (score_valid),
        .score_data  (score_data),
        .score_ready (score_ready),
        .pred_valid  (pred_valid),
        .pred_ready  (pred_ready),
        .predict     (predict),
        .max_score   (max_score),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [NC-1:0][DW-1:0] s;
        logic [7:0]            pred;
        logic [DW-1:0]         mx;
    } vec_t;

    typedef struct {
        logic [7:0]    pred;
        logic [DW-1:0] mx;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] sx(input int v);
        return DW'(v);
    endfunction

    // Reference argmax: first class seeds the maximum, strict > keeps lowest index on ties.
    function automatic exp_t model(input logic [NC-1:0][DW-1:0] s);
        exp_t e;
        e.pred = 8'd0;
        e.mx   = s[0];
        for (int k = 1; k < NC; k++) begin
            if ($signed(s[k]) > $signed(e.mx)) begin
                e.mx   = s[k];
                e.pred = 8'(k);
            end
        end
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},       64'(busy),        64'd0);
        chk({tag, "_score_req"},  64'(score_req),   64'd0);
        chk({tag, "_score_idx"},  64'(score_idx),   64'd0);
        chk({tag, "_score_ready"},64'(score_ready), 64'd0);
        chk({tag, "_pred_valid"}, 64'(pred_valid),  64'd0);
        chk({tag, "_predict"},    64'(predict),     64'd0);
        chk({tag, "_max_score"},  64'(max_score),   64'd0);
    endtask

    task automatic run_image(input vec_t v, input bit rand_delay, input int hold, input bit start_on_ack);
        exp_t e;
        exp_t got;
        int   start_cyc;
        int   t;
        e.pred = v.pred;
        e.mx   = v.mx;
        sb.push_back(e);
        start     = 1'b1;
        start_cyc = cyc + 1;
        tick();
        start = 1'b0;
        chk("proto_err_cleared", 64'(proto_err), 64'd0);
        for (int k = 0; k < NC; k++) begin
            t = 0;
            while (!score_req && t < 8) begin
                tick();
                t++;
            end
            chk("score_req", 64'(score_req), 64'd1);
            chk("score_idx", 64'(score_idx), 64'(k));
            tick();
            chk("score_ready", 64'(score_ready), 64'd1);
            if (rand_delay) repeat ($urandom_range(0, 3)) tick();
            score_valid = 1'b1;
            score_data  = v.s[k];
            tick();
            score_valid = 1'b0;
            score_data  = '0;
        end
        t = 0;
        while (!pred_valid && t < 8) begin
            tick();
            t++;
        end
        chk("pred_valid", 64'(pred_valid), 64'd1);
        if (!rand_delay) chk("latency", 64'(cyc - start_cyc), 64'd20);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
            got = e;
        end else begin
            got = sb.pop_front();
        end
        chk("predict", 64'(predict), 64'(got.pred));
        chk("max_score", 64'(max_score), 64'(got.mx));
        for (int i = 0; i < hold; i++) begin
            start = (i == 2);
            tick();
            chk("hold_valid",   64'(pred_valid), 64'd1);
            chk("hold_busy",    64'(busy),       64'd1);
            chk("hold_predict", 64'(predict),    64'(got.pred));
            chk("hold_max",     64'(max_score),  64'(got.mx));
        end
        start      = start_on_ack;
        pred_ready = 1'b1;
        tick();
        start      = 1'b0;
        pred_ready = 1'b0;
        chk("pred_valid_drop", 64'(pred_valid), 64'd0);
        chk("idle_busy",       64'(busy),       64'd0);
        tick();
        chk("no_restart",     64'(score_req), 64'd0);
        chk("idle_busy2",     64'(busy),      64'd0);
        chk("idle_hold_pred", 64'(predict),   64'(got.pred));
        chk("idle_hold_max",  64'(max_score), 64'(got.mx));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   tbl0[NC];
        exp_t m;
        int   t;
        tbl0 = '{5, -3, 7, 7, 0, 1, 2, 3, 4, 6};
        for (int k = 0; k < NC; k++) begin
            vecs[0].s[k] = sx(tbl0[k]);
            vecs[1].s[k] = sx(k - 10);
            vecs[2].s[k] = (k == 0) ? MAXP : (k == 1) ? MINN : '0;
            vecs[3].s[k] = (k == 5) ? MAXP : MINN;
            vecs[4].s[k] = DW'({$urandom(), $urandom()});
            vecs[5].s[k] = sx(int'($urandom_range(0, 6)) - 3);
        end
        vecs[0].pred = 8'd2; vecs[0].mx = sx(7);
        vecs[1].pred = 8'd9; vecs[1].mx = sx(-1);
        vecs[2].pred = 8'd0; vecs[2].mx = MAXP;
        vecs[3].pred = 8'd5; vecs[3].mx = MAXP;
        for (int i = 4; i < 6; i++) begin
            m = model(vecs[i].s);
            vecs[i].pred = m.pred;
            vecs[i].mx   = m.mx;
        end

        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");
        chk("reset_proto_err", 64'(proto_err), 64'd0);

        // Stray score while idle.
        score_valid = 1'b1;
        score_data  = sx(123);
        tick();
        score_valid = 1'b0;
        chk("idle_stray_proto_err", 64'(proto_err), 64'd1);
        chk("idle_stray_busy",      64'(busy),      64'd0);
        chk("idle_stray_req",       64'(score_req), 64'd0);
        tick();
        chk("idle_stray_req2",      64'(score_req), 64'd0);
        chk("idle_stray_busy2",     64'(busy),      64'd0);

        for (int i = 0; i < 6; i++) begin
            run_image(vecs[i], i >= 4, (i >= 4) ? 5 : 0, i == 5);
        end

        // Abort with reset during WAIT of class 4, then a stray score.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            t = 0;
            while (!score_req && t < 8) begin
                tick();
                t++;
            end
            chk("abort_score_idx", 64'(score_idx), 64'(k));
            tick();
            if (k < 4) begin
                score_valid = 1'b1;
                score_data  = vecs[1].s[k];
                tick();
                score_valid = 1'b0;
            end
        end
        chk("abort_in_wait", 64'(score_ready), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("abort");
        chk("abort_proto_err", 64'(proto_err), 64'd0);
        score_valid = 1'b1;
        score_data  = sx(55);
        tick();
        score_valid = 1'b0;
        check_reset_outputs("stray");
        chk("stray_proto_err", 64'(proto_err), 64'd1);
        tick();

        run_image(vecs[0], 1'b0, 0, 1'b0);
        chk("final_proto_err", 64'(proto_err), 64'd0);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/argmax_scheduler.md
Name: argmax_scheduler

Overview:
- Sequences the time-shared output layer one class at a time. For each class it issues a request, receives that class's signed score, and keeps a running signed maximum.
- After the last class it presents the predicted class index to the downstream consumer (UART/LED/result FIFO) through a valid/ready handshake.
- Replaces the parallel 10-score compare tree when the output neurons are folded onto one MAC.

Parameters:
- DATA_WIDTH, 42, width of one class score (two's complement).
- NUM_CLASSES, 10, number of output classes; legal range 2..16.
- IDX_WIDTH, 4, width of class index; must satisfy 2^IDX_WIDTH >= NUM_CLASSES.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  begin classification of a new image; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- score_req  out  1  one-cycle pulse: compute score for score_idx
- score_idx  out  IDX_WIDTH  class currently requested; stable from ISSUE until the score is accepted
- score_valid  in  1  score_data is valid
- score_data  in  DATA_WIDTH  signed score of class score_idx
- score_ready  out  1  high only in WAIT
- pred_valid  out  1  prediction available
- pred_ready  in  1  consumer accepts prediction
- predict  out  8  winning class index, zero-extended
- max_score  out  DATA_WIDTH  winning score
- proto_err  out  1  sticky flag: score_valid seen outside WAIT

Behaviour:
- Reset values: busy=0, score_req=0, score_idx=0, score_ready=0, pred_valid=0, predict=0, max_score=0, proto_err=0. Reset also forces the state to IDLE and the class counter k to 0.
- Reset asserted mid-operation aborts the run. All registers return to reset values on that edge. A score arriving in the next cycle is a stray score.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 -> ISSUE, k=0, proto_err cleared.
  - Otherwise stay in IDLE.
- ISSUE:
  - score_req=1 and score_idx=k for exactly one cycle.
  - Always -> WAIT.
- WAIT:
  - score_ready=1.
  - On score_valid&score_ready:
    - if k==0, load best_score=score_data and best_idx=0 unconditionally;
    - else if signed(score_data) > signed(best_score), update best_score/best_idx=k.
  - Then:
    - if k==NUM_CLASSES-1 -> DONE;
    - else k<=k+1 -> ISSUE.
  - Without score_valid, stay in WAIT indefinitely (no timeout).
- DONE:
  - pred_valid=1, predict={0,best_idx}, max_score=best_score.
  - predict and max_score are registered and held stable while pred_valid&!pred_ready.
  - On pred_ready -> IDLE; pred_valid drops the next cycle.
  - predict and max_score keep their values in IDLE until the next run loads class 0.
- Compare rules:
  - Full DATA_WIDTH signed two's-complement comparison.
  - Strict greater-than, so ties keep the lowest index.
  - No saturation and no truncation.
- Latency: with score_valid high on the first WAIT cycle of every class, each class takes 2 cycles. pred_valid rises 2*NUM_CLASSES cycles after the start edge (20 at default).
- start while busy is ignored and not queued. start and pred_ready asserted together in DONE: complete the handshake to IDLE and ignore start.
- score_valid outside WAIT: data ignored, state unchanged, proto_err<=1 (sticky until the next accepted start).

Decomposition:
- Shared package/header holds:
  - DATA_WIDTH, NUM_CLASSES, IDX_WIDTH defaults;
  - state encodings S_IDLE=0, S_ISSUE=1, S_WAIT=2, S_DONE=3.
- Natural sub-module: score_max_update. It is combinational; inputs are first, new score/idx, and current best. Outputs are the next best score/idx, using the signed strict-greater rule. It is reused by any future folded classifier.

Test Plan:
- Scores [5,-3,7,7,0,1,2,3,4,6], zero-wait -> predict=2 (tie keeps 2), max_score=7, pred_valid rises exactly 20 cycles after start.
- Scores -10,-9,...,-1 for classes 0..9 -> predict=9, max_score=-1 (all-negative path, first-load correctness).
- class0=2^41-1, class1=-2^41, others 0 -> predict=0, max_score=2^41-1. Then a second run with class5=2^41-1 and all others -2^41 -> predict=5.
- Random 0..3-cycle score_valid delays per class; pred_ready held low 5 cycles with start pulsed meanwhile -> predict/max_score stable, start ignored, a single handshake, then IDLE with busy=0.
- rst pulsed during WAIT of class 4, then a stray score_valid next cycle -> all outputs at reset values, proto_err=1. A following start clears proto_err and completes correctly.
- score_valid asserted in IDLE with no start -> proto_err=1, busy stays 0, no score_req generated.
